// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_state_t : FSM state codes (gray sequence through a frame)
//   PAR_*        : parity type selector values
//   *_BIT/LVL    : line levels for start, stop and idle
//   cnt_width()  : bit-counter width for a given data width
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_START  = 3'b001,
    S_DATA   = 3'b011,
    S_PARITY = 3'b010,
    S_STOP   = 3'b110
  } uart_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Counter only has to reach DATA_WIDTH-1; keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the UART transmitter.
// Ports:
//   clk_i        baud clock
//   rst_i        async active-high reset
//   load_i       capture load_data_i, clear bit counter
//   load_data_i  parallel word to serialize
//   shift_i      shift register right by one (LSB leaves first)
//   count_i      advance bit counter
//   ser_data_o   current LSB of the shift register
//   ser_done_o   bit counter at DATA_WIDTH-1 (last data bit on the line)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  shift_i,
  input  logic                  count_i,
  output logic                  ser_data_o,
  output logic                  ser_done_o
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_data_i;
      cnt_d   = '0;
    end else begin
      if (shift_i) shreg_d = shreg_q >> 1;
      if (count_i) cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_data_o = shreg_q[0];
  assign ser_done_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, one stop bit. One serial bit per CLK cycle.
// Ports:
//   CLK         TX baud clock
//   RST         async active-high reset
//   P_DATA      parallel word, sampled on accept
//   Data_Valid  request, accepted in IDLE
//   PAR_EN      1 = append parity bit, sampled on accept
//   PAR_TYP     0 = even, 1 = odd, sampled on accept
//   TX_OUT      registered serial line, idles high
//   Busy        registered, high from start bit through stop bit
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit on the line
// DATA   | data bits on the line, LSB first
// PARITY | latched parity bit on the line
// STOP   | stop bit on the line, Busy drops at end of cycle
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_state_t state_q;
  logic        tx_q;
  logic        busy_q;
  logic        par_en_q;
  logic        par_bit_q;

  logic        accept;
  logic        ser_shift;
  logic        ser_count;
  logic        ser_data;
  logic        ser_done;

  assign accept = (state_q == S_IDLE) && Data_Valid;

  // Outputs are registered, so each edge loads the bit for the state being
  // entered. The first shift happens leaving START (bit 0 goes onto the line);
  // the counter only advances between data bits, so it reads DATA_WIDTH-1
  // while the last bit is on the line.
  assign ser_shift = (state_q == S_START) || ((state_q == S_DATA) && !ser_done);
  assign ser_count = (state_q == S_DATA) && !ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (accept),
    .load_data_i (P_DATA),
    .shift_i     (ser_shift),
    .count_i     (ser_count),
    .ser_data_o  (ser_data),
    .ser_done_o  (ser_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Data_Valid) begin
            state_q   <= S_START;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
          end else begin
            tx_q   <= IDLE_LVL;
            busy_q <= 1'b0;
          end
        end
        S_START: begin
          state_q <= S_DATA;
          tx_q    <= ser_data;
        end
        S_DATA: begin
          if (ser_done) begin
            if (par_en_q) begin
              state_q <= S_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= S_STOP;
              tx_q    <= STOP_BIT;
            end
          end else begin
            tx_q <= ser_data;
          end
        end
        S_PARITY: begin
          state_q <= S_STOP;
          tx_q    <= STOP_BIT;
        end
        S_STOP: begin
          state_q <= S_IDLE;
          tx_q    <= IDLE_LVL;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= IDLE_LVL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core. Expected line sequences are written out
// by hand as strings, earliest bit first.
module tb_uart_tx_core;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request on the next falling edge; accepted on the following rise.
  task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
  endtask

  // Sample one cycle per expected bit with Busy high, then one idle cycle.
  // On the first (start-bit) cycle the inputs are replaced by nd/np, and
  // Data_Valid is dropped if drop_dv is set.
  task automatic run_frame(input string tag, input string exp, input logic drop_dv,
                           input logic [7:0] nd, input logic np);
    for (int i = 0; i < exp.len(); i++) begin
      @(negedge CLK);
      if (i == 0) begin
        P_DATA  = nd;
        PAR_TYP = np;
        if (drop_dv) Data_Valid = 1'b0;
      end
      check($sformatf("%s tx[%0d]", tag, i), {31'd0, TX_OUT}, {31'd0, exp.getc(i) == 8'h31});
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, Busy}, 32'd1);
    end
    @(negedge CLK);
    check($sformatf("%s idle tx", tag), {31'd0, TX_OUT}, 32'd1);
    check($sformatf("%s idle busy", tag), {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    string pre;
    RST        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    #12;
    check("reset tx", {31'd0, TX_OUT}, 32'd1);
    check("reset busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle tx", {31'd0, TX_OUT}, 32'd1);
    check("idle busy", {31'd0, Busy}, 32'd0);

    // 0xA5, no parity
    start_frame(8'hA5, 1'b0, 1'b0);
    run_frame("t1", "0101001011", 1'b1, 8'hA5, 1'b0);

    // 0xA5 even parity -> 0, odd parity -> 1
    start_frame(8'hA5, 1'b1, 1'b0);
    run_frame("t2e", "01010010101", 1'b1, 8'hA5, 1'b0);
    start_frame(8'hA5, 1'b1, 1'b1);
    run_frame("t2o", "01010010111", 1'b1, 8'hA5, 1'b1);

    // 0x00 odd parity
    start_frame(8'h00, 1'b1, 1'b1);
    run_frame("t3", "00000000011", 1'b1, 8'h00, 1'b1);

    // Request held high; 0x3C replaces 0xA5 on the bus mid-frame
    start_frame(8'hA5, 1'b0, 1'b0);
    run_frame("t4a", "0101001011", 1'b0, 8'h3C, 1'b0);
    run_frame("t4b", "0001111001", 1'b1, 8'h3C, 1'b0);

    // Reset while data bit 4 is on the line
    start_frame(8'hA5, 1'b0, 1'b0);
    pre = "010100";
    for (int i = 0; i < pre.len(); i++) begin
      @(negedge CLK);
      if (i == 0) Data_Valid = 1'b0;
      check($sformatf("t5 tx[%0d]", i), {31'd0, TX_OUT}, {31'd0, pre.getc(i) == 8'h31});
      check($sformatf("t5 busy[%0d]", i), {31'd0, Busy}, 32'd1);
    end
    #1 RST = 1'b1;
    #1;
    check("t5 async tx", {31'd0, TX_OUT}, 32'd1);
    check("t5 async busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("t5 post tx", {31'd0, TX_OUT}, 32'd1);
    check("t5 post busy", {31'd0, Busy}, 32'd0);
    start_frame(8'h00, 1'b1, 1'b1);
    run_frame("t5r", "00000000011", 1'b1, 8'h00, 1'b1);

    // Inputs change right after accept: latched 0xA5 even parity must go out
    start_frame(8'hA5, 1'b1, 1'b0);
    run_frame("t6", "01010010101", 1'b1, 8'h3C, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
